serial_bcd_alu_p: RTL and testbench
===================================

Name: serial_bcd_alu_p

Overview:
- Parametrised, multi-op successor to the serial BCD adder.
- Accepts one bit-serial frame containing an opcode and two DIGITS-digit BCD operands.
- Computes add, signed-magnitude subtract or compare digit-serially, then shifts a (DIGITS+1)-digit BCD result word out bit-serially with a valid strobe.
- Sits between the serial command link and the result-capture shift register.

Parameters:
DIGITS, 4, operand width in BCD digits (1..8); result word width RW = 4*(DIGITS+1) bits.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
en  input  1  frame enable; high for exactly FL = 2+8*DIGITS cycles per frame.
in  input  1  serial frame data, sampled on clk when en=1.
result  output  1  serial result bit, LSB first; 0 when result_valid=0.
result_valid  output  1  high during each of the RW result bit cycles.
busy  output  1  high from the first sampled frame bit until the last result bit.
err  output  1  high throughout the output phase of an errored frame.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. On reset, all outputs = 0, FSM = IDLE, bit counter = 0 and the operand registers are cleared. Reset asserted mid-frame or mid-output aborts immediately, with no partial output after release.
- Frame format, in sampling order:
  - op[0], op[1];
  - A digit 0 bit 0 … A digit DIGITS-1 bit 3 (LSB first, least-significant digit first);
  - B in the same order.
- Frame arming: a frame starts on the first cycle with en=1 while in IDLE, and only if en was 0 on the previous cycle (armed flag). en held high straight out of OUT does not start a frame.
- FSM states: IDLE, LOAD, CALC, OUT.
  - IDLE -> LOAD: en=1 and armed; bit 0 is captured and busy rises on the same edge.
  - LOAD: captures one bit per cycle.
    - If en=0 before FL bits are captured, discard the frame and return to IDLE with no output and err=0.
    - After bit FL-1 is captured, go to CALC.
  - CALC: exactly DIGITS cycles, processing one digit per cycle from the LSD.
    - The sum A+B and both differences A-B and B-A are computed in parallel, with carry/borrow registered between digits.
    - Digit correction: sum>9 -> +6 with carry; difference<0 -> +10 with borrow.
    - en is ignored.
  - OUT: exactly RW cycles.
    - result = word[k] in cycle k; result_valid = 1.
    - Then go to IDLE; busy falls on that same edge.
- Latency: the first result bit appears DIGITS+1 cycles after the edge that samples frame bit FL-1.
- Op 00 ADD: word = A+B; top digit = final carry (0 or 1).
- Op 01 SUB:
  - If A>=B: top digit 0, lower digits = A-B.
  - If A<B: top digit 1, lower digits = B-A.
- Op 10 CMP: digit 0 = 1 if A>B, 0 if A=B, 2 if A<B; all other digits 0.
- Errors: op 11, or any A/B nibble >9 (checked as each nibble completes in LOAD).
  - Effect: word = all ones (RW bits) and err = 1 during OUT.
  - An errored frame still takes the full CALC+OUT time.
- Simultaneous events: rst dominates everything; en=1 during CALC/OUT is ignored and does not arm.

Decomposition:
- Package serial_bcd_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_BAD=2'b11;
  - the FSM state enum;
  - CMP code constants GT=1, EQ=0, LT=2.
- One sub-module, bcd_digit_addsub: combinational single-digit BCD add/subtract.
  - Inputs: a[3:0], b[3:0], cin, sub.
  - Outputs: d[3:0], cout/bout.
  - Instantiated three times (sum, A-B, B-A).

Test Plan (DIGITS=4, FL=34, RW=20):
1. ADD A=9999, B=0001 -> after 5-cycle latency, 20 serial bits form 0x10000; result_valid high 20 cycles; err=0.
2. SUB A=0123, B=0456 -> word 0x10333. Then SUB A=0456, B=0123 -> 0x00333. Then SUB A=B=0777 -> 0x00000.
3. CMP triple: 5000 vs 4999 -> 0x00001; 4999 vs 5000 -> 0x00002; 2024 vs 2024 -> 0x00000.
4. Error cases: ADD with A=0x12A4 -> word 0xFFFFF with err=1 for 20 cycles; op 11 with valid operands -> same.
5. Framing: en dropped after 17 bits -> no result_valid, busy falls next cycle. en held high across consecutive frames -> the second frame is ignored until en has gone low for one cycle.
6. Reset: rst pulsed (asynchronously, between edges) during OUT bit 7 -> result, result_valid, busy and err go to 0 immediately. A following valid ADD 0005+0005 -> 0x00010.

Source files
------------

// File: rtl/serial_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_bcd_pkg
// Brief   : Shared opcodes, FSM states and compare codes for serial_bcd_alu_p
// Revision: 1.0 - initial release
// ============================================================================
package serial_bcd_pkg;

   // Two-bit opcode carried at the head of each frame
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b10;
   localparam logic [1:0] OP_BAD = 2'b11;

   // Frame-processing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   // Compare result codes placed in digit 0 of the result word
   localparam logic [3:0] GT = 4'd1;
   localparam logic [3:0] EQ = 4'd0;
   localparam logic [3:0] LT = 4'd2;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_addsub.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_addsub
// Brief   : Combinational single-digit BCD adder / subtractor with carry or
//           borrow in and out
// Revision: 1.0 - initial release
// ============================================================================
module bcd_digit_addsub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] d,
   output logic       cout
);

   logic [4:0] w_sum;
   logic [4:0] w_diff;

   // Binary sum/difference, then decimal correction (+6 on overflow, +10 on underflow)
   always_comb begin
      w_sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      w_diff = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
      if (sub) begin
         cout = w_diff[4];
         d    = w_diff[4] ? (w_diff[3:0] + 4'd10) : w_diff[3:0];
      end else begin
         cout = (w_sum > 5'd9);
         d    = (w_sum > 5'd9) ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_bcd_alu_p.sv
`default_nettype none
// ============================================================================
// Module  : serial_bcd_alu_p
// Brief   : Bit-serial BCD ALU. Loads an opcode plus two DIGITS-digit BCD
//           operands, computes add / signed-magnitude subtract / compare one
//           digit per cycle, then streams a (DIGITS+1)-digit result LSB first.
// Revision: 1.0 - initial release
// ============================================================================
module serial_bcd_alu_p
   import serial_bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic in,
   output logic result,
   output logic result_valid,
   output logic busy,
   output logic err
);

   localparam int FL = 2 + 8 * DIGITS;
   localparam int RW = 4 * (DIGITS + 1);
   localparam int OW = 4 * DIGITS;
   localparam int CW = $clog2(FL + 1);

   localparam logic [CW-1:0] c_FL_LAST   = CW'(FL - 1);
   localparam logic [CW-1:0] c_RW_LAST   = CW'(RW - 1);
   localparam logic [CW-1:0] c_CALC_LAST = CW'(DIGITS - 1);

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            r_armed;
   logic [1:0]      r_op;
   logic            r_err;
   // Operands: B in the upper half, A in the lower half; shifted down a digit per CALC cycle
   logic [2*OW-1:0] r_ab;
   logic [OW-1:0]   r_sum;
   logic [OW-1:0]   r_dab;
   logic [OW-1:0]   r_dba;
   logic            r_c;
   logic            r_bab;
   logic            r_bba;
   logic [RW-1:0]   r_word;

   logic [OW-1:0]   w_a;
   logic [OW-1:0]   w_b;
   logic [3:0]      w_sum_d;
   logic [3:0]      w_dab_d;
   logic [3:0]      w_dba_d;
   logic            w_cout;
   logic            w_bab;
   logic            w_bba;
   logic [OW+3:0]   w_sum_cat;
   logic [OW+3:0]   w_dab_cat;
   logic [OW+3:0]   w_dba_cat;
   logic [OW-1:0]   w_sum_n;
   logic [OW-1:0]   w_dab_n;
   logic [OW-1:0]   w_dba_n;
   logic [RW-1:0]   w_word;

   assign w_a = r_ab[OW-1:0];
   assign w_b = r_ab[2*OW-1:OW];

   // Three digit slices run in parallel: A+B, A-B and B-A
   bcd_digit_addsub u_sum (
      .a    (w_a[3:0]),
      .b    (w_b[3:0]),
      .cin  (r_c),
      .sub  (1'b0),
      .d    (w_sum_d),
      .cout (w_cout)
   );

   bcd_digit_addsub u_dab (
      .a    (w_a[3:0]),
      .b    (w_b[3:0]),
      .cin  (r_bab),
      .sub  (1'b1),
      .d    (w_dab_d),
      .cout (w_bab)
   );

   bcd_digit_addsub u_dba (
      .a    (w_b[3:0]),
      .b    (w_a[3:0]),
      .cin  (r_bba),
      .sub  (1'b1),
      .d    (w_dba_d),
      .cout (w_bba)
   );

   // New digits enter at the top so after DIGITS steps the LSD sits at bit 0
   assign w_sum_cat = {w_sum_d, r_sum};
   assign w_dab_cat = {w_dab_d, r_dab};
   assign w_dba_cat = {w_dba_d, r_dba};
   assign w_sum_n   = w_sum_cat[OW+3:4];
   assign w_dab_n   = w_dab_cat[OW+3:4];
   assign w_dba_n   = w_dba_cat[OW+3:4];

   // Result word assembled from the final-digit values on the last CALC cycle
   always_comb begin
      w_word = '0;
      if (r_err) begin
         w_word = '1;
      end else begin
         case (r_op)
            OP_ADD:  w_word = {3'b000, w_cout, w_sum_n};
            OP_SUB:  w_word = w_bab ? {4'd1, w_dba_n} : {4'd0, w_dab_n};
            OP_CMP:  w_word[3:0] = w_bab ? LT : ((w_dab_n == '0) ? EQ : GT);
            default: w_word = '1;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (en && r_armed) w_next = ST_LOAD;
         ST_LOAD: begin
            if (!en)                    w_next = ST_IDLE;
            else if (r_cnt == c_FL_LAST) w_next = ST_CALC;
         end
         ST_CALC: if (r_cnt == c_CALC_LAST) w_next = ST_OUT;
         ST_OUT:  if (r_cnt == c_RW_LAST)   w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; all drop together on reset
   always_comb begin
      result_valid = (r_state == ST_OUT);
      result       = (r_state == ST_OUT) & r_word[0];
      busy         = (r_state != ST_IDLE);
      err          = (r_state == ST_OUT) & r_err;
   end

   // Datapath: frame capture, digit-serial arithmetic and result shifting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_armed <= 1'b0;
         r_op    <= '0;
         r_err   <= 1'b0;
         r_ab    <= '0;
         r_sum   <= '0;
         r_dab   <= '0;
         r_dba   <= '0;
         r_c     <= 1'b0;
         r_bab   <= 1'b0;
         r_bba   <= 1'b0;
         r_word  <= '0;
      end else begin
         // A frame may only start after en has been seen low
         r_armed <= ~en;
         case (r_state)
            ST_IDLE: begin
               if (en && r_armed) begin
                  r_op  <= {in, 1'b0};
                  r_err <= 1'b0;
                  r_ab  <= '0;
                  r_sum <= '0;
                  r_dab <= '0;
                  r_dba <= '0;
                  r_c   <= 1'b0;
                  r_bab <= 1'b0;
                  r_bba <= 1'b0;
                  r_cnt <= CW'(1);
               end
            end
            ST_LOAD: begin
               if (!en) begin
                  r_cnt <= '0;
               end else begin
                  if (r_cnt == CW'(1)) begin
                     r_op <= {in, r_op[1]};
                     if ({in, r_op[1]} == OP_BAD) r_err <= 1'b1;
                  end else begin
                     r_ab <= {in, r_ab[2*OW-1:1]};
                     // Bit indices 5, 9, 13, ... complete an operand nibble
                     if ((r_cnt[1:0] == 2'b01) && ({in, r_ab[2*OW-1 -: 3]} > 4'd9))
                        r_err <= 1'b1;
                  end
                  r_cnt <= (r_cnt == c_FL_LAST) ? '0 : r_cnt + 1'b1;
               end
            end
            ST_CALC: begin
               r_ab  <= {w_b >> 4, w_a >> 4};
               r_sum <= w_sum_n;
               r_dab <= w_dab_n;
               r_dba <= w_dba_n;
               r_c   <= w_cout;
               r_bab <= w_bab;
               r_bba <= w_bba;
               if (r_cnt == c_CALC_LAST) begin
                  r_word <= w_word;
                  r_cnt  <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_OUT: begin
               r_word <= r_word >> 1;
               r_cnt  <= (r_cnt == c_RW_LAST) ? '0 : r_cnt + 1'b1;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_bcd_alu_p.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_bcd_alu_p
// Brief   : Self-checking bench for serial_bcd_alu_p (DIGITS=4) with directed
//           and random frames against a decimal-arithmetic reference model
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_bcd_alu_p;

   localparam int DIGITS = 4;
   localparam int FL     = 2 + 8 * DIGITS;
   localparam int RW     = 4 * (DIGITS + 1);

   logic clk;
   logic rst;
   logic en;
   logic din;
   logic result;
   logic result_valid;
   logic busy;
   logic err;

   int n_checks;
   int n_errors;

   serial_bcd_alu_p #(.DIGITS(DIGITS)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .in           (din),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] to_bcd(input int v);
      logic [RW-1:0] w;
      int x;
      w = '0;
      x = v;
      for (int i = 0; i < DIGITS + 1; i++) begin
         w[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return w;
   endfunction

   function automatic int from_bcd(input logic [4*DIGITS-1:0] b);
      int v;
      v = 0;
      for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
      return v;
   endfunction

   // Reference: plain decimal arithmetic on the operand values
   task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [RW-1:0] w, output logic e);
      int av;
      int bv;
      e = (op == 2'b11);
      for (int i = 0; i < DIGITS; i++)
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e = 1'b1;
      av = from_bcd(a);
      bv = from_bcd(b);
      if (e) w = '1;
      else if (op == 2'b00) w = to_bcd(av + bv);
      else if (op == 2'b01) w = (av >= bv) ? to_bcd(av - bv) : (to_bcd(bv - av) | to_bcd(10000));
      else w = (av > bv) ? RW'(1) : ((av == bv) ? RW'(0) : RW'(2));
   endtask

   // Send a full frame and check the timing, word and flags of the response
   task automatic run_frame(input string tag, input logic [1:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [RW-1:0] exp_w,
                            input logic exp_e, input bit hold_en);
      logic [FL-1:0] fr;
      logic [RW-1:0] got;
      int nvalid;
      int nerr;
      int first;
      int stray;
      fr = {b, a, op};
      @(negedge clk); en = 1'b0; din = 1'b0;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk); en = 1'b1; din = fr[i];
      end
      got = '0; nvalid = 0; nerr = 0; first = -1; stray = 0;
      for (int k = 1; k <= DIGITS + RW + 1; k++) begin
         @(negedge clk);
         if (k == 1) check({tag, "_busy_calc"}, 32'(busy), 32'd1);
         if (result_valid) begin
            if (first < 0) first = k;
            if (nvalid < RW) got[nvalid] = result;
            nvalid++;
            if (err) nerr++;
         end else if (result || err) begin
            stray++;
         end
         if (hold_en) din = 1'($urandom);
         else begin en = 1'b0; din = 1'b0; end
      end
      check({tag, "_word"},    32'(got),    32'(exp_w));
      check({tag, "_latency"}, 32'(first),  32'(DIGITS + 1));
      check({tag, "_nvalid"},  32'(nvalid), 32'(RW));
      check({tag, "_err"},     32'(nerr),   exp_e ? 32'(RW) : 32'd0);
      check({tag, "_stray"},   32'(stray),  32'd0);
      check({tag, "_busy_end"}, 32'(busy),  32'd0);
   endtask

   task automatic rand_frame(input int idx);
      logic [1:0]    op;
      logic [RW-1:0] t;
      logic [15:0]   a;
      logic [15:0]   b;
      logic [RW-1:0] w;
      logic          e;
      op = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      t = to_bcd(int'($urandom_range(0, 9999))); a = t[15:0];
      t = to_bcd(int'($urandom_range(0, 9999))); b = t[15:0];
      if ($urandom_range(0, 4) == 0) b = a;
      if ($urandom_range(0, 9) == 0) a[4*$urandom_range(0, 3) +: 4] = 4'(10 + $urandom_range(0, 5));
      model(op, a, b, w, e);
      run_frame($sformatf("rnd%0d", idx), op, a, b, w, e, 1'b0);
   endtask

   initial begin
      int nv;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; en = 1'b0; din = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({result, result_valid, busy, err}), 32'd0);
      rst = 1'b0;

      // Directed arithmetic cases
      run_frame("add_9999_1", 2'b00, 16'h9999, 16'h0001, 20'h10000, 1'b0, 1'b0);
      run_frame("sub_lt",     2'b01, 16'h0123, 16'h0456, 20'h10333, 1'b0, 1'b0);
      run_frame("sub_gt",     2'b01, 16'h0456, 16'h0123, 20'h00333, 1'b0, 1'b0);
      run_frame("sub_eq",     2'b01, 16'h0777, 16'h0777, 20'h00000, 1'b0, 1'b0);
      run_frame("cmp_gt",     2'b10, 16'h5000, 16'h4999, 20'h00001, 1'b0, 1'b0);
      run_frame("cmp_lt",     2'b10, 16'h4999, 16'h5000, 20'h00002, 1'b0, 1'b0);
      run_frame("cmp_eq",     2'b10, 16'h2024, 16'h2024, 20'h00000, 1'b0, 1'b0);
      run_frame("err_nib",    2'b00, 16'h12A4, 16'h0001, 20'hFFFFF, 1'b1, 1'b0);
      run_frame("err_op",     2'b11, 16'h1234, 16'h0001, 20'hFFFFF, 1'b1, 1'b0);

      // Truncated frame: en drops after 17 bits
      @(negedge clk); en = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk); en = 1'b1; din = 1'($urandom);
      end
      @(negedge clk); en = 1'b0; din = 1'b0;
      check("trunc_busy_hold", 32'(busy), 32'd1);
      @(negedge clk);
      check("trunc_busy_fall", 32'(busy), 32'd0);
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid || busy) nv++;
      end
      check("trunc_no_output", 32'(nv), 32'd0);

      // en held high past the end of a frame: no restart until it drops
      run_frame("hold_first", 2'b00, 16'h0250, 16'h0750, 20'h01000, 1'b0, 1'b1);
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); din = 1'($urandom);
         if (busy) nv++;
      end
      check("hold_no_restart", 32'(nv), 32'd0);
      run_frame("hold_rearm", 2'b01, 16'h1000, 16'h0001, 20'h00999, 1'b0, 1'b0);

      // Asynchronous reset during OUT bit 7 of an errored frame
      @(negedge clk); en = 1'b0;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk); en = 1'b1; din = ({16'h0001, 16'h0001, 2'b11} >> i) & 34'd1;
      end
      @(negedge clk); en = 1'b0; din = 1'b0;
      repeat (DIGITS + 7) @(negedge clk);
      check("rst_pre_outputs", 32'({result, result_valid, busy, err}), 32'hF);
      #2 rst = 1'b1;
      #1 check("rst_async_outputs", 32'({result, result_valid, busy, err}), 32'd0);
      #1 rst = 1'b0;
      nv = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (result_valid || busy || err || result) nv++;
      end
      check("rst_no_resume", 32'(nv), 32'd0);
      run_frame("post_rst_add", 2'b00, 16'h0005, 16'h0005, 20'h00010, 1'b0, 1'b0);

      // Random frames against the decimal model
      for (int n = 0; n < 25; n++) rand_frame(n);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
